// File: rtl/axis_pkt_source.sv
// axis_pkt_source: AXI4-Stream packet master with whole-packet buffering.
// Words arrive on a valid/ready write port and are held in an internal FIFO.
// A packet is released onto the stream only after its last word is
// committed. TDEST is taken from the top bits of the first word,
// TUSER[0] flags the first beat and TLAST flags the last one.
//
// Optional feature macro: AXIS_SRC_ABORT_EN (adds in_abort).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready write handshake; in_data word; in_last commits packet
//   in_abort          (AXIS_SRC_ABORT_EN only) discard uncommitted words
//   m_axis_*          AXI4-Stream master (tvalid/tready/tdata/tlast/tdest/tuser)
//   level             words stored, committed and uncommitted
//   err_ovf           sticky overflow flag; err_clr clears it
module axis_pkt_source #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DEST_W = 8,
    parameter int unsigned USER_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
`ifdef AXIS_SRC_ABORT_EN
    input  logic                    in_abort,
`endif
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [DEST_W-1:0]       m_axis_tdest,
    output logic [USER_W-1:0]       m_axis_tuser,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err_ovf,
    input  logic                    err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic { RD_IDLE, RD_SEND } rd_state_t;
    typedef enum logic { WR_NORM, WR_DROP } wr_state_t;

    rd_state_t rd_state, rd_state_n;
    wr_state_t wr_state, wr_state_n;

    // Entries are {last, data}.
    logic [DATA_W:0] mem [DEPTH];

    // wr_ptr: next write slot; wr_cmt: end of committed data;
    // rd_ptr: next entry to load into the output register;
    // free_ptr: oldest slot still owned (advances on stream handshake),
    // so the beat held in the output register still counts as stored.
    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] wr_cmt, wr_cmt_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [PW-1:0] free_ptr, free_ptr_n;
    logic [PW-1:0] pkt_cnt, pkt_cnt_n;
    logic [PW-1:0] level_n;

    logic              tvalid_n, tlast_n, in_ready_n, err_n;
    logic [DATA_W-1:0] tdata_n;
    logic [DEST_W-1:0] tdest_n;
    logic [USER_W-1:0] tuser_n;

    logic            abort_c, wr_fire_c, hs_c, full_c;
    logic            mem_we_c, pkt_inc_c, pkt_dec_c, ovf_c, load_c, load_first_c;
    logic [DATA_W:0] rd_entry_c;

`ifdef AXIS_SRC_ABORT_EN
    assign abort_c = in_abort;
`else
    assign abort_c = 1'b0;
`endif

    assign wr_fire_c  = in_valid && in_ready;
    assign hs_c       = m_axis_tvalid && m_axis_tready;
    assign full_c     = (wr_ptr - free_ptr) == PW'(DEPTH);
    assign rd_entry_c = mem[rd_ptr[AW-1:0]];

    // FIFO storage; only committed slots are ever read, so no read/write hazard.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
        end
    end

    // Next-state logic for the write side, read FSM and status outputs.
    always_comb begin
        wr_state_n   = wr_state;
        wr_ptr_n     = wr_ptr;
        wr_cmt_n     = wr_cmt;
        mem_we_c     = 1'b0;
        pkt_inc_c    = 1'b0;
        ovf_c        = 1'b0;
        rd_state_n   = rd_state;
        rd_ptr_n     = rd_ptr;
        free_ptr_n   = free_ptr;
        pkt_dec_c    = 1'b0;
        load_c       = 1'b0;
        load_first_c = 1'b0;
        tvalid_n     = m_axis_tvalid;
        tdata_n      = m_axis_tdata;
        tlast_n      = m_axis_tlast;
        tdest_n      = m_axis_tdest;
        tuser_n      = m_axis_tuser;

        // Write side: abort beats everything, then DROP, then overflow check.
        if (abort_c) begin
            wr_ptr_n   = wr_cmt;
            wr_state_n = WR_NORM;
        end else if (wr_state == WR_DROP) begin
            if (wr_fire_c && in_last) begin
                wr_state_n = WR_NORM;
            end
        end else if (full_c && (wr_cmt == free_ptr)) begin
            // Full of a single unfinished packet: it can never drain.
            wr_ptr_n   = wr_cmt;
            wr_state_n = WR_DROP;
            ovf_c      = 1'b1;
        end else if (wr_fire_c) begin
            mem_we_c = 1'b1;
            wr_ptr_n = wr_ptr + PW'(1);
            if (in_last) begin
                wr_cmt_n  = wr_ptr + PW'(1);
                pkt_inc_c = 1'b1;
            end
        end

        // Read side.
        if (hs_c) begin
            free_ptr_n = free_ptr + PW'(1);
        end

        unique case (rd_state)
            RD_IDLE: begin
                if (pkt_cnt != '0) begin
                    load_c       = 1'b1;
                    load_first_c = 1'b1;
                    rd_state_n   = RD_SEND;
                end
            end
            RD_SEND: begin
                if (hs_c && m_axis_tlast) begin
                    pkt_dec_c = 1'b1;
                    // Current packet is still counted in pkt_cnt.
                    if (pkt_cnt > PW'(1)) begin
                        load_c       = 1'b1;
                        load_first_c = 1'b1;
                    end else begin
                        tvalid_n   = 1'b0;
                        rd_state_n = RD_IDLE;
                    end
                end else if (hs_c || !m_axis_tvalid) begin
                    if (rd_ptr != wr_cmt) begin
                        load_c = 1'b1;
                    end else begin
                        tvalid_n = 1'b0;
                    end
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase

        if (load_c) begin
            tvalid_n = 1'b1;
            tdata_n  = rd_entry_c[DATA_W-1:0];
            tlast_n  = rd_entry_c[DATA_W];
            tuser_n  = USER_W'(load_first_c);
            rd_ptr_n = rd_ptr + PW'(1);
            if (load_first_c) begin
                tdest_n = rd_entry_c[DATA_W-1 -: DEST_W];
            end
        end

        pkt_cnt_n  = pkt_cnt + PW'(pkt_inc_c) - PW'(pkt_dec_c);
        level_n    = wr_ptr_n - free_ptr_n;
        in_ready_n = (level_n != PW'(DEPTH)) || (wr_state_n == WR_DROP);
        // A same-cycle overflow wins over err_clr.
        err_n      = ovf_c ? 1'b1 : (err_clr ? 1'b0 : err_ovf);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state      <= RD_IDLE;
            wr_state      <= WR_NORM;
            wr_ptr        <= '0;
            wr_cmt        <= '0;
            rd_ptr        <= '0;
            free_ptr      <= '0;
            pkt_cnt       <= '0;
            level         <= '0;
            in_ready      <= 1'b0;
            err_ovf       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
        end else begin
            rd_state      <= rd_state_n;
            wr_state      <= wr_state_n;
            wr_ptr        <= wr_ptr_n;
            wr_cmt        <= wr_cmt_n;
            rd_ptr        <= rd_ptr_n;
            free_ptr      <= free_ptr_n;
            pkt_cnt       <= pkt_cnt_n;
            level         <= level_n;
            in_ready      <= in_ready_n;
            err_ovf       <= err_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tlast  <= tlast_n;
            m_axis_tdest  <= tdest_n;
            m_axis_tuser  <= tuser_n;
        end
    end

endmodule

// File: tb/tb_axis_pkt_source.sv
// Directed testbench for axis_pkt_source (DATA_W=32, DEPTH=16, DEST_W=8, USER_W=4).
module tb_axis_pkt_source;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DEST_W = 8;
    localparam int unsigned USER_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
`ifdef AXIS_SRC_ABORT_EN
    logic              in_abort = 1'b0;
`endif
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic [DEST_W-1:0] m_axis_tdest;
    logic [USER_W-1:0] m_axis_tuser;
    logic [4:0]        level;
    logic              err_ovf;
    logic              err_clr = 1'b0;

    axis_pkt_source #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DEST_W(DEST_W), .USER_W(USER_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef AXIS_SRC_ABORT_EN
        .in_abort(in_abort),
`endif
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .level(level), .err_ovf(err_ovf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [7:0]  dest;
        logic [3:0]  user;
        int          c;
    } beat_t;

    beat_t q[$];
    beat_t mb;

    // Beat collector: a handshake is decided by values stable at the negedge.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            mb.d    = m_axis_tdata;
            mb.l    = m_axis_tlast;
            mb.dest = m_axis_tdest;
            mb.user = m_axis_tuser;
            mb.c    = cyc;
            q.push_back(mb);
        end
    end

    // Called and returns just after a rising edge.
    task automatic wr(input logic [31:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL wr_timeout: in_ready=%b want 1 for word %h", in_ready, d);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 100 && q.size() < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        total++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser} !== 46'h0) begin
            bad++; $display("FAIL rst_axis: got %h want 0",
                {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser});
        end
        total++;
        if (level !== 5'd0 || err_ovf !== 1'b0) begin
            bad++; $display("FAIL rst_status: got level=%0d err=%b want 0 0", level, err_ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(2);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [31:0] exp_d [3] = '{32'hA5000001, 32'h00000002, 32'h00000003};
        logic [44:0] got, want;
        q.delete();
        m_axis_tready = 1'b1;
        wr(32'hA5000001, 1'b0);
        wr(32'h00000002, 1'b0);
        wr(32'h00000003, 1'b1);
        @(negedge clk);
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_lat_early: tvalid=%b want 0", m_axis_tvalid); end
        @(negedge clk);
        total++;
        if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL single_lat: tvalid=%b want 1", m_axis_tvalid); end
        wait_cycles(6);
        total++;
        if (q.size() != 3) begin
            bad++; $display("FAIL single_count: got %0d want 3", q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got  = {q[i].d, q[i].l, q[i].dest, q[i].user};
                want = {exp_d[i], (i == 2), 8'hA5, 4'(i == 0)};
                total++;
                if (got !== want) begin bad++; $display("FAIL single_beat%0d: got %h want %h", i, got, want); end
            end
        end
        total++;
        if (level !== 5'd0) begin bad++; $display("FAIL single_level: got %0d want 0", level); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [3] = '{32'hA5000001, 32'h00000002, 32'h00000003};
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [45:0] snap = '0;
        logic [44:0] got, want;
        bit          stalled = 1'b0;
        int          n = 0;
        q.delete();
        m_axis_tready = 1'b0;
        wr(32'hA5000001, 1'b0);
        wr(32'h00000002, 1'b0);
        wr(32'h00000003, 1'b1);
        @(negedge clk);
        while (!m_axis_tvalid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL bp_start: tvalid=%b want 1", m_axis_tvalid); end
        for (int k = 0; k < 40 && q.size() < 3; k++) begin
            @(posedge clk); #1;
            m_axis_tready = pat[k % 4];
            @(negedge clk);
            if (stalled) begin
                total++;
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser} !== snap) begin
                    bad++; $display("FAIL bp_stable: got %h want %h",
                        {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser}, snap);
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            snap    = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser};
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_cycles(5);
        total++;
        if (q.size() != 3) begin
            bad++; $display("FAIL bp_count: got %0d want 3", q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got  = {q[i].d, q[i].l, q[i].dest, q[i].user};
                want = {exp_d[i], (i == 2), 8'hA5, 4'(i == 0)};
                total++;
                if (got !== want) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got, want); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [44:0] want [3];
        logic [44:0] got;
        want[0] = {32'h11000000, 1'b1, 8'h11, 4'h1};
        want[1] = {32'h22000000, 1'b0, 8'h22, 4'h1};
        want[2] = {32'h00000005, 1'b1, 8'h22, 4'h0};
        q.delete();
        m_axis_tready = 1'b0;
        wr(32'h11000000, 1'b1);
        wr(32'h22000000, 1'b0);
        wr(32'h00000005, 1'b1);
        wait_cycles(3);
        m_axis_tready = 1'b1;
        wait_beats(3);
        wait_cycles(3);
        total++;
        if (q.size() != 3) begin
            bad++; $display("FAIL b2b_count: got %0d want 3", q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = {q[i].d, q[i].l, q[i].dest, q[i].user};
                total++;
                if (got !== want[i]) begin bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, want[i]); end
            end
            total++;
            if (q[1].c - q[0].c != 1 || q[2].c - q[1].c != 1) begin
                bad++; $display("FAIL b2b_gap: got gaps %0d %0d want 1 1", q[1].c - q[0].c, q[2].c - q[1].c);
            end
        end
    endtask

    task automatic test_overflow();
        logic [44:0] got;
        q.delete();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            wr(32'(i), i == 20);
            if (i == 16) begin
                @(negedge clk);
                total++;
                if (level !== 5'd16) begin bad++; $display("FAIL ovf_full_level: got %0d want 16", level); end
                @(negedge clk);
                total++;
                if (err_ovf !== 1'b1 || level !== 5'd0) begin
                    bad++; $display("FAIL ovf_flag: got err=%b level=%0d want 1 0", err_ovf, level);
                end
                @(posedge clk); #1;
            end
        end
        wait_cycles(5);
        total++;
        if (q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            bad++; $display("FAIL ovf_no_output: got beats=%0d tvalid=%b want 0 0", q.size(), m_axis_tvalid);
        end
        total++;
        if (level !== 5'd0 || err_ovf !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL ovf_after: got level=%0d err=%b rdy=%b want 0 1 1", level, err_ovf, in_ready);
        end
        m_axis_tready = 1'b1;
        wr(32'h33000007, 1'b1);
        wait_beats(1);
        wait_cycles(3);
        total++;
        if (q.size() != 1) begin
            bad++; $display("FAIL ovf_next_count: got %0d want 1", q.size());
        end else begin
            got = {q[0].d, q[0].l, q[0].dest, q[0].user};
            total++;
            if (got !== {32'h33000007, 1'b1, 8'h33, 4'h1}) begin
                bad++; $display("FAIL ovf_next_beat: got %h want %h", got, {32'h33000007, 1'b1, 8'h33, 4'h1});
            end
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        total++;
        if (err_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", err_ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_committed();
        logic [44:0] got, want;
        logic [7:0]  pd;
        q.delete();
        m_axis_tready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int w = 0; w < 4; w++) begin
                pd = 8'h40 + 8'(p);
                wr({pd, 24'(w)}, w == 3);
            end
        end
        wait_cycles(3);
        total++;
        if (in_ready !== 1'b0 || err_ovf !== 1'b0 || level !== 5'd16) begin
            bad++; $display("FAIL full_state: got rdy=%b err=%b level=%0d want 0 0 16", in_ready, err_ovf, level);
        end
        m_axis_tready = 1'b1;
        wait_beats(16);
        wait_cycles(4);
        total++;
        if (q.size() != 16) begin
            bad++; $display("FAIL full_count: got %0d want 16", q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                pd   = 8'h40 + 8'(i / 4);
                got  = {q[i].d, q[i].l, q[i].dest, q[i].user};
                want = {pd, 24'(i % 4), (i % 4 == 3), pd, 4'(i % 4 == 0)};
                total++;
                if (got !== want) begin bad++; $display("FAIL full_beat%0d: got %h want %h", i, got, want); end
            end
        end
        total++;
        if (in_ready !== 1'b1 || level !== 5'd0) begin
            bad++; $display("FAIL full_drained: got rdy=%b level=%0d want 1 0", in_ready, level);
        end
    endtask

`ifdef AXIS_SRC_ABORT_EN
    task automatic test_abort();
        logic [44:0] got;
        q.delete();
        m_axis_tready = 1'b1;
        wr(32'h77000001, 1'b0);
        wr(32'h00000002, 1'b0);
        wr(32'h00000003, 1'b0);
        @(negedge clk);
        total++;
        if (level !== 5'd3) begin bad++; $display("FAIL abort_pre_level: got %0d want 3", level); end
        @(posedge clk); #1;
        in_abort = 1'b1;
        @(posedge clk); #1;
        in_abort = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 5'd0 || err_ovf !== 1'b0) begin
            bad++; $display("FAIL abort_level: got level=%0d err=%b want 0 0", level, err_ovf);
        end
        @(posedge clk); #1;
        wr(32'h88000009, 1'b1);
        wait_beats(1);
        wait_cycles(3);
        total++;
        if (q.size() != 1) begin
            bad++; $display("FAIL abort_count: got %0d want 1", q.size());
        end else begin
            got = {q[0].d, q[0].l, q[0].dest, q[0].user};
            total++;
            if (got !== {32'h88000009, 1'b1, 8'h88, 4'h1}) begin
                bad++; $display("FAIL abort_next: got %h want %h", got, {32'h88000009, 1'b1, 8'h88, 4'h1});
            end
        end
    endtask
`endif

    task automatic test_reset_midpkt();
        m_axis_tready = 1'b0;
        wr(32'h99000001, 1'b0);
        wr(32'h00000002, 1'b1);
        wait_cycles(3);
        total++;
        if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL midrst_pre: tvalid=%b want 1", m_axis_tvalid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_clear: got tvalid=%b level=%0d rdy=%b want 0 0 0",
                m_axis_tvalid, level, in_ready);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        q.delete();
        m_axis_tready = 1'b1;
        wait_cycles(6);
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL midrst_lost: got %0d beats want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_committed();
`ifdef AXIS_SRC_ABORT_EN
        test_abort();
`endif
        test_reset_midpkt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
